// File: rtl/ota_cmp_pkg.sv
// Shared definitions for the comparator decimator slice.
// Contents: FSM state encoding, default parameter values, derived window and
// settle lengths for the defaults, and a saturating 8-bit increment helper.
package ota_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_LEN     = 4;
    localparam int DEF_WIN_LOG2    = 8;
    localparam int DEF_OUT_W       = 8;

    localparam int WIN_LEN    = 1 << DEF_WIN_LOG2;
    localparam int SETTLE_LEN = DEF_SYNC_STAGES + DEF_DEB_LEN;

    // Increment an 8-bit counter by inc, sticking at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val, input logic inc);
        logic [7:0] res;
        if (inc && (val != 8'hFF)) begin
            res = val + 8'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/ota_cmp_debounce.sv
// Synchronizer plus run-length debounce filter for the raw comparator bit.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   clear       - synchronous soft clear of chain, filter and run counter
//   cmp_in      - raw comparator output, asynchronous to clk
//   cmp_filt    - filtered decision; flips only after DEB_LEN consecutive
//                 synchronized samples disagree with it
module ota_cmp_debounce
    import ota_cmp_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_LEN     = DEF_DEB_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic cmp_in,
    output logic cmp_filt
);

    localparam int RUN_W = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [RUN_W-1:0]       run_cnt_r;
    logic                   filt_r;
    logic                   cmp_s;

    assign cmp_s    = sync_r[SYNC_STAGES-1];
    assign cmp_filt = filt_r;

    // Synchronizer shift chain; sample enters at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else if (clear) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], cmp_in};
        end
    end

    // Run-length filter: count consecutive disagreeing samples, flip on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r    <= 1'b0;
            run_cnt_r <= '0;
        end else if (clear) begin
            filt_r    <= 1'b0;
            run_cnt_r <= '0;
        end else if (cmp_s != filt_r) begin
            if (run_cnt_r == RUN_LAST) begin
                filt_r    <= ~filt_r;
                run_cnt_r <= '0;
            end else begin
                run_cnt_r <= run_cnt_r + RUN_W'(1);
            end
        end else begin
            run_cnt_r <= '0;
        end
    end

endmodule

// File: rtl/ota_cmp_decimator.sv
// Decimates the debounced comparator decision over 2^WIN_LOG2-cycle windows.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   cmp_in         - raw comparator output (asynchronous)
//   enable         - level; 1 runs settle + back-to-back windows
//   clear          - synchronous soft clear (wins over window completion)
//   cmp_filt       - synchronized, debounced decision (always running)
//   density        - ones-density code of the last complete window
//   toggles        - cmp_filt transitions in the last window, saturating at 255
//   density_valid  - one-cycle pulse when density/toggles/overrange update
//   overrange      - last window was all ones
module ota_cmp_decimator
    import ota_cmp_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_LEN     = DEF_DEB_LEN,
    parameter int WIN_LOG2    = DEF_WIN_LOG2,
    parameter int OUT_W       = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmp_in,
    input  logic             enable,
    input  logic             clear,
    output logic             cmp_filt,
    output logic [OUT_W-1:0] density,
    output logic [7:0]       toggles,
    output logic             density_valid,
    output logic             overrange
);

    localparam int CNT_W  = WIN_LOG2 + 1;
    localparam int SET_LEN = SYNC_STAGES + DEB_LEN;
    localparam int SET_W  = $clog2(SET_LEN) + 1;
    localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SET_LEN - 1);
    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

    state_e               state_r, state_s;
    logic [SET_W-1:0]     settle_r;
    logic [WIN_LOG2-1:0]  win_r;
    logic [CNT_W-1:0]     ones_r;
    logic [7:0]           tog_r;
    logic                 filt_d_r;
    logic [OUT_W-1:0]     density_r;
    logic [7:0]           toggles_r;
    logic                 valid_r;
    logic                 over_r;

    logic                 cmp_filt_s;
    logic [CNT_W-1:0]     count_s;
    logic [7:0]           tog_final_s;
    logic [OUT_W-1:0]     dens_next_s;
    logic                 over_next_s;
    logic                 win_end_s;

    ota_cmp_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_LEN     (DEB_LEN)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .cmp_in   (cmp_in),
        .cmp_filt (cmp_filt_s)
    );

    assign cmp_filt      = cmp_filt_s;
    assign density       = density_r;
    assign toggles       = toggles_r;
    assign density_valid = valid_r;
    assign overrange     = over_r;

    // FSM state register; clear forces IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_s = ST_IDLE;
                end else if (settle_r == SET_LAST) begin
                    state_s = ST_ACCUM;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_ACCUM: begin
                if (!enable) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Window arithmetic: the final count includes the current cycle's sample.
    always_comb begin
        count_s     = ones_r + CNT_W'(cmp_filt_s);
        tog_final_s = sat_inc8(tog_r, cmp_filt_s ^ filt_d_r);
        dens_next_s = '1;
        over_next_s = 1'b1;
        win_end_s   = 1'b0;
        if (count_s[WIN_LOG2]) begin
            dens_next_s = '1;
            over_next_s = 1'b1;
        end else begin
            dens_next_s = count_s[WIN_LOG2-1 -: OUT_W];
            over_next_s = 1'b0;
        end
        if ((state_r == ST_ACCUM) && (win_r == WIN_LAST)) begin
            win_end_s = 1'b1;
        end else begin
            win_end_s = 1'b0;
        end
    end

    // Counters, accumulators and result registers. A window end reports even
    // if enable falls on the same edge; clear overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r  <= '0;
            win_r     <= '0;
            ones_r    <= '0;
            tog_r     <= 8'd0;
            filt_d_r  <= 1'b0;
            density_r <= '0;
            toggles_r <= 8'd0;
            valid_r   <= 1'b0;
            over_r    <= 1'b0;
        end else if (clear) begin
            settle_r  <= '0;
            win_r     <= '0;
            ones_r    <= '0;
            tog_r     <= 8'd0;
            filt_d_r  <= 1'b0;
            density_r <= '0;
            toggles_r <= 8'd0;
            valid_r   <= 1'b0;
            over_r    <= 1'b0;
        end else begin
            // Tracking every cycle means the last SETTLE cycle seeds the compare.
            filt_d_r <= cmp_filt_s;
            valid_r  <= 1'b0;
            case (state_r)
                ST_SETTLE: begin
                    settle_r <= settle_r + SET_W'(1);
                    win_r    <= '0;
                    ones_r   <= '0;
                    tog_r    <= 8'd0;
                end
                ST_ACCUM: begin
                    settle_r <= '0;
                    win_r    <= win_r + WIN_LOG2'(1);
                    if (win_end_s) begin
                        ones_r    <= '0;
                        tog_r     <= 8'd0;
                        density_r <= dens_next_s;
                        toggles_r <= tog_final_s;
                        over_r    <= over_next_s;
                        valid_r   <= 1'b1;
                    end else begin
                        ones_r <= count_s;
                        tog_r  <= tog_final_s;
                    end
                end
                default: begin
                    settle_r <= '0;
                    win_r    <= '0;
                    ones_r   <= '0;
                    tog_r    <= 8'd0;
                end
            endcase
        end
    end

endmodule
